rng_lfsr_checker: RTL and testbench

//  Receive-side checker for the 12-bit LFSR noise stream (taps 11,10,9,3; shift left, feedback into bit 0).

---
 rtl/rng_lfsr_checker.sv | 147 ++++++++++++++
 tb/tb_rng_lfsr_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_lfsr_checker.sv
// Receive-side checker for the 12-bit LFSR noise stream (taps 11,10,9,3).
// Self-synchronises, flywheels a prediction while locked, and counts mismatches.
module rng_lfsr_checker #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [11:0]      i_data,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_sample_cnt
);

  localparam int unsigned DW    = 12;
  localparam int unsigned RUN_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] LOSS_RUN = RUN_W'(LOSS_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] x);
    return {x[10:0], x[11] ^ x[10] ^ x[9] ^ x[3]};
  endfunction

  logic [1:0]       state_q,      state_d;
  logic [DW-1:0]    ref_q,        ref_d;
  logic [RUN_W-1:0] good_run_q,   good_run_d;
  logic [RUN_W-1:0] bad_run_q,    bad_run_d;
  logic             locked_q,     locked_d;
  logic             err_q,        err_d;
  logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  logic [DW-1:0]    pred_c;
  logic             nonzero_c;
  logic             match_c;
  logic [RUN_W-1:0] good_inc_c;
  logic [RUN_W-1:0] bad_inc_c;

  // An all-zero word is never part of the sequence, so it can never match.
  always_comb begin
    pred_c     = lfsr_next(ref_q);
    nonzero_c  = |i_data;
    match_c    = nonzero_c && (i_data == pred_c);
    good_inc_c = good_run_q + RUN_W'(1);
    bad_inc_c  = bad_run_q + RUN_W'(1);
  end

  // Next-state and output logic; only valid cycles advance anything.
  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    good_run_d   = good_run_q;
    bad_run_d    = bad_run_q;
    locked_d     = locked_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;

    if (i_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (nonzero_c) begin
            ref_d      = i_data;
            good_run_d = '0;
            state_d    = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (match_c) begin
            good_run_d = good_inc_c;
            ref_d      = i_data;
            if (good_inc_c == LOCK_RUN) begin
              state_d   = ST_LOCKED;
              locked_d  = 1'b1;
              bad_run_d = '0;
            end
          end else begin
            good_run_d = '0;
            if (nonzero_c) begin
              ref_d = i_data;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_LOCKED: begin
          sample_cnt_d = (sample_cnt_q == CNT_MAX) ? sample_cnt_q : sample_cnt_q + CNT_W'(1);
          // Flywheel: keep following the predicted sequence through corrupt words.
          ref_d = pred_c;
          if (match_c) begin
            bad_run_d = '0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            bad_run_d = bad_inc_c;
            if (bad_inc_c == LOSS_RUN) begin
              locked_d   = 1'b0;
              good_run_d = '0;
              ref_d      = i_data;
              state_d    = nonzero_c ? ST_SEARCH : ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      ref_q        <= '0;
      good_run_q   <= '0;
      bad_run_q    <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      good_run_q   <= good_run_d;
      bad_run_q    <= bad_run_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign o_locked     = locked_q;
  assign o_err        = err_q;
  assign o_err_cnt    = err_cnt_q;
  assign o_sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_rng_lfsr_checker.sv
// Bench for rng_lfsr_checker: hand-derived vector table plus a queue scoreboard
// fed by a behavioural model, run against 16-bit and 4-bit counter instances.
module tb_rng_lfsr_checker;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic [11:0] i_data;

  logic        locked_a, err_a;
  logic [15:0] err_cnt_a, sample_cnt_a;
  logic        locked_b, err_b;
  logic [3:0]  err_cnt_b, sample_cnt_b;

  rng_lfsr_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_locked(locked_a), .o_err(err_a), .o_err_cnt(err_cnt_a), .o_sample_cnt(sample_cnt_a)
  );

  rng_lfsr_checker #(.LOCK_COUNT(8), .LOSS_COUNT(4), .CNT_W(4)) dut_w4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_locked(locked_b), .o_err(err_b), .o_err_cnt(err_cnt_b), .o_sample_cnt(sample_cnt_b)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] lfsr_next(input logic [11:0] x);
    return {x[10:0], ^(x & 12'hE08)};
  endfunction

  function automatic int sat(input int x, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  // Stream generator
  logic [11:0] gen;
  task automatic take_word(output logic [11:0] w);
    w   = gen;
    gen = lfsr_next(gen);
  endtask

  // Behavioural model
  localparam int M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2;
  int          m_state, m_good, m_bad, m_errs, m_samps;
  logic [11:0] m_ref;
  bit          m_locked, m_err;

  task automatic model_step(input bit rst_n, input bit v, input logic [11:0] d);
    logic [11:0] p;
    if (!rst_n) begin
      m_state = M_IDLE; m_ref = '0; m_good = 0; m_bad = 0;
      m_locked = 0; m_err = 0; m_errs = 0; m_samps = 0;
    end else begin
      m_err = 0;
      p = lfsr_next(m_ref);
      if (v) begin
        if (m_state == M_IDLE) begin
          if (d != 0) begin m_ref = d; m_good = 0; m_state = M_SEARCH; end
        end else if (m_state == M_SEARCH) begin
          if (d != 0 && d == p) begin
            m_good++;
            m_ref = d;
            if (m_good == 8) begin m_state = M_LOCKED; m_locked = 1; m_bad = 0; end
          end else begin
            m_good = 0;
            if (d != 0) m_ref = d;
            else m_state = M_IDLE;
          end
        end else begin
          m_samps++;
          m_ref = p;
          if (d == p) m_bad = 0;
          else begin
            m_err = 1; m_errs++; m_bad++;
            if (m_bad == 4) begin
              m_locked = 0; m_good = 0; m_ref = d;
              m_state = (d != 0) ? M_SEARCH : M_IDLE;
            end
          end
        end
      end
    end
  endtask

  // Scoreboard
  typedef struct {
    bit locked;
    bit err;
    int errs;
    int samps;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  always @(posedge i_clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_locked",    int'(locked_a),     int'(mon_e.locked));
      check("sb_err",       int'(err_a),        int'(mon_e.err));
      check("sb_err_cnt",   int'(err_cnt_a),    sat(mon_e.errs, 16));
      check("sb_smp_cnt",   int'(sample_cnt_a), sat(mon_e.samps, 16));
      check("sb4_locked",   int'(locked_b),     int'(mon_e.locked));
      check("sb4_err",      int'(err_b),        int'(mon_e.err));
      check("sb4_err_cnt",  int'(err_cnt_b),    sat(mon_e.errs, 4));
      check("sb4_smp_cnt",  int'(sample_cnt_b), sat(mon_e.samps, 4));
    end
  end

  task automatic drive(input bit rst_n, input bit v, input logic [11:0] d);
    @(negedge i_clk);
    i_rst   = rst_n;
    i_valid = v;
    i_data  = d;
    model_step(rst_n, v, d);
    sb_q.push_back('{m_locked, m_err, m_errs, m_samps});
  endtask

  task automatic settle();
    @(posedge i_clk);
    #2;
  endtask

  // Vector table
  localparam int K_IDLE = 0, K_GOOD = 1, K_ZERO = 2, K_BAD = 3, K_RST = 4;
  typedef struct {
    int kind;
    bit exp_locked;
    bit exp_err;
    int exp_ec;
    int exp_sc;
  } vec_t;
  vec_t vec[$];

  task automatic add(input int kind, input bit l, input bit e, input int ec, input int sc);
    vec.push_back('{kind, l, e, ec, sc});
  endtask

  task automatic drive_good(input int n);
    logic [11:0] w;
    for (int k = 0; k < n; k++) begin
      take_word(w);
      drive(1'b1, 1'b1, w);
    end
  endtask

  task automatic drive_bad(input int n);
    logic [11:0] w;
    for (int k = 0; k < n; k++) begin
      take_word(w);
      drive(1'b1, 1'b1, ~w);
    end
  endtask

  initial begin
    logic [11:0] w;
    int n_valid;
    i_rst = 1'b0; i_valid = 1'b0; i_data = '0;
    gen = 12'hACE;

    // Lock, single zero word, four-word burst loss, relock, mid-lock reset
    for (int k = 0; k < 8; k++) add(K_GOOD, 0, 0, 0, 0);
    add(K_GOOD, 1, 0, 0, 0);
    add(K_IDLE, 1, 0, 0, 0);
    add(K_GOOD, 1, 0, 0, 1);
    add(K_GOOD, 1, 0, 0, 2);
    add(K_ZERO, 1, 1, 1, 3);
    add(K_GOOD, 1, 0, 1, 4);
    add(K_GOOD, 1, 0, 1, 5);
    add(K_BAD,  1, 1, 2, 6);
    add(K_BAD,  1, 1, 3, 7);
    add(K_BAD,  1, 1, 4, 8);
    add(K_BAD,  0, 1, 5, 9);
    add(K_IDLE, 0, 0, 5, 9);
    for (int k = 0; k < 8; k++) add(K_GOOD, 0, 0, 5, 9);
    add(K_GOOD, 1, 0, 5, 9);
    add(K_GOOD, 1, 0, 5, 10);
    add(K_RST,  0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(K_GOOD, 0, 0, 0, 0);
    add(K_GOOD, 1, 0, 0, 0);

    drive(1'b0, 1'b0, 12'h000);
    settle();
    check("rst_locked", int'(locked_a), 0);
    check("rst_err_cnt", int'(err_cnt_a), 0);

    foreach (vec[i]) begin
      case (vec[i].kind)
        K_IDLE:  drive(1'b1, 1'b0, 12'h5A5);
        K_GOOD:  begin take_word(w); drive(1'b1, 1'b1, w); end
        K_ZERO:  begin take_word(w); drive(1'b1, 1'b1, 12'h000); end
        K_BAD:   begin take_word(w); drive(1'b1, 1'b1, ~w); end
        default: begin take_word(w); drive(1'b0, 1'b1, w); end
      endcase
      settle();
      check($sformatf("tbl%0d_locked", i), int'(locked_a),     int'(vec[i].exp_locked));
      check($sformatf("tbl%0d_err", i),    int'(err_a),        int'(vec[i].exp_err));
      check($sformatf("tbl%0d_err_cnt", i), int'(err_cnt_a),   vec[i].exp_ec);
      check($sformatf("tbl%0d_smp_cnt", i), int'(sample_cnt_a), vec[i].exp_sc);
    end

    // Random valid gaps
    drive(1'b0, 1'b0, 12'h000);
    gen = 12'hACE;
    n_valid = 0;
    for (int k = 0; k < 300 && n_valid < 40; k++) begin
      if ($urandom_range(99) < 30) begin
        drive(1'b1, 1'b0, 12'($urandom));
      end else begin
        take_word(w);
        drive(1'b1, 1'b1, w);
        n_valid++;
      end
    end
    settle();
    check("gap_valid_count", n_valid, 40);
    check("gap_locked", int'(locked_a), 1);
    check("gap_smp_cnt", int'(sample_cnt_a), n_valid - 9);

    // Constant streams never lock
    drive(1'b0, 1'b0, 12'h000);
    for (int k = 0; k < 50; k++) drive(1'b1, 1'b1, 12'h000);
    for (int k = 0; k < 50; k++) drive(1'b1, 1'b1, 12'hACE);
    settle();
    check("const_locked", int'(locked_a), 0);
    check("const_err_cnt", int'(err_cnt_a), 0);

    // Error counter saturation with 4-bit counters, then mid-lock reset
    drive(1'b0, 1'b0, 12'h000);
    gen = 12'hACE;
    drive_good(9);
    for (int r = 0; r < 7; r++) begin
      drive_bad(3);
      drive_good(1);
    end
    settle();
    check("sat_locked", int'(locked_a), 1);
    check("sat_err_cnt16", int'(err_cnt_a), 21);
    check("sat_err_cnt4", int'(err_cnt_b), 15);
    check("sat_smp_cnt16", int'(sample_cnt_a), 28);
    check("sat_smp_cnt4", int'(sample_cnt_b), 15);

    take_word(w);
    drive(1'b0, 1'b1, w);
    settle();
    check("midrst_locked", int'(locked_a), 0);
    check("midrst_err_cnt", int'(err_cnt_a), 0);
    check("midrst_smp_cnt", int'(sample_cnt_a), 0);
    drive_good(8);
    settle();
    check("relock_8", int'(locked_a), 0);
    drive_good(1);
    settle();
    check("relock_9", int'(locked_a), 1);

    repeat (3) @(posedge i_clk);
    #2;
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
